// File: rtl/vector_alu_seq.sv
// Sequential vector ALU: one op per start/done handshake on W-bit operands.
// Latency: 1 cycle for logic/arith/saturating ops, W+2 cycles for signed MUL.
// Backpressure: start is ignored while busy; no queueing, done is a 1-cycle pulse.
module vector_alu_seq #(
  parameter  int W     = 8,
  localparam int CNT_W = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [4:0]     alu_op,
  input  logic [W-1:0]   r,
  input  logic [W-1:0]   s,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   y,
  output logic [2*W-1:0] y2,
  output logic           ovf
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_PASS = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_ADDS = 5'b00110;
  localparam logic [4:0] OP_SUBS = 5'b00111;
  localparam logic [4:0] OP_MUL  = 5'b01000;
  localparam logic [4:0] OP_MULH = 5'b01001;
  localparam logic [4:0] OP_CMP  = 5'b01010;

  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_SIGN} state_t;

  state_t           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [W-1:0]     r_q, r_d, s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     mr_q, mr_d;
  logic             sign_q, sign_d;
  logic [2*W:0]     p_q, p_d;
  logic [W-1:0]     y_q, y_d;
  // y2_q doubles as the retained product register read back by MULH.
  logic [2*W-1:0]   y2_q, y2_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Single-cycle datapath on the latched operands.
  logic [W:0]       add_ext, sub_ext;
  logic [W-1:0]     alu_y;
  logic             alu_ovf;
  logic [2*W:0]     p_add;
  logic [2*W-1:0]   prod_signed;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? (~v + 1'b1) : v;
  endfunction

  // Result mux for the one-cycle ops; saturation uses a sign-extended W+1 bit sum.
  always_comb begin
    add_ext = {r_q[W-1], r_q} + {s_q[W-1], s_q};
    sub_ext = {r_q[W-1], r_q} - {s_q[W-1], s_q};
    alu_ovf = 1'b0;
    alu_y   = s_q;
    case (op_q)
      OP_ADD:  alu_y = r_q + s_q;
      OP_PASS: alu_y = s_q;
      OP_SUB:  alu_y = r_q - s_q;
      OP_AND:  alu_y = r_q & s_q;
      OP_OR:   alu_y = r_q | s_q;
      OP_XOR:  alu_y = r_q ^ s_q;
      OP_ADDS: begin
        alu_ovf = add_ext[W] ^ add_ext[W-1];
        alu_y   = alu_ovf ? (add_ext[W] ? SMIN : SMAX) : add_ext[W-1:0];
      end
      OP_SUBS: begin
        alu_ovf = sub_ext[W] ^ sub_ext[W-1];
        alu_y   = alu_ovf ? (sub_ext[W] ? SMIN : SMAX) : sub_ext[W-1:0];
      end
      OP_MULH: alu_y = y2_q[2*W-1:W];
      OP_CMP:  alu_y = ((r_q & s_q) == r_q) ? {W{1'b1}} : {W{1'b0}};
      default: alu_y = s_q;
    endcase
  end

  // Next-state and datapath register updates for the handshake FSM.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    r_d     = r_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    mr_d    = mr_q;
    sign_d  = sign_q;
    p_d     = p_q;
    y_d     = y_q;
    y2_d    = y2_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    // Shift-add step: add |r| into the upper half (carry kept), then shift right.
    p_add       = p_q[0] ? {p_q[2*W:W] + {1'b0, mr_q}, p_q[W-1:0]} : p_q;
    prod_signed = sign_q ? (~p_q[2*W-1:0] + 1'b1) : p_q[2*W-1:0];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = alu_op;
          r_d     = r;
          s_d     = s;
          cnt_d   = '0;
          state_d = (alu_op == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        y_d     = alu_y;
        ovf_d   = alu_ovf;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          mr_d   = mag(r_q);
          sign_d = r_q[W-1] ^ s_q[W-1];
          p_d    = {{(W+1){1'b0}}, mag(s_q)};
          cnt_d  = CNT_W'(1);
        end else begin
          p_d = p_add >> 1;
          if (cnt_q == CNT_W'(W)) begin
            state_d = S_SIGN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_SIGN: begin
        // A zero magnitude negates to zero, so no -0 artefact can appear.
        y2_d    = prod_signed;
        y_d     = prod_signed[W-1:0];
        ovf_d   = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      r_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      mr_q    <= '0;
      sign_q  <= 1'b0;
      p_q     <= '0;
      y_q     <= '0;
      y2_q    <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      r_q     <= r_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      mr_q    <= mr_d;
      sign_q  <= sign_d;
      p_q     <= p_d;
      y_q     <= y_d;
      y2_q    <= y2_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign y    = y_q;
  assign y2   = y2_q;
  assign ovf  = ovf_q;

endmodule
